// File: rtl/cdb_arbiter_rr.sv
// cdb_arbiter_rr: grants one completing source per cycle onto the Common Data Bus
// and registers its tag/data as the broadcast; fixed-priority or round-robin.
module cdb_arbiter_rr #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 3,
    parameter bit RR_MODE = 1'b1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_SRC-1:0]          req,
    input  logic [NUM_SRC*TAG_W-1:0]    tag,
    input  logic [NUM_SRC*DATA_W-1:0]   data,
    input  logic                        hold,
    output logic [NUM_SRC-1:0]          grant,
    output logic                        cdb_valid,
    output logic [TAG_W-1:0]            qi_cdb,
    output logic [DATA_W-1:0]           qi_cdb_data,
    output logic [$clog2(NUM_SRC)-1:0]  rr_ptr
);
    localparam int PW = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] pick;
    logic [PW-1:0]      idx;
    logic [PW-1:0]      ptr_nxt;
    logic [TAG_W-1:0]   sel_tag;
    logic [DATA_W-1:0]  sel_data;

    // Tag 0 means "no producer", so such a request can never reach the bus
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_elig
        assign elig[i] = req[i] && (|tag[i*TAG_W +: TAG_W]);
    end

    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = RR_MODE ? PW'((int'(rr_ptr) + k) % NUM_SRC) : PW'(k);
            if (pick == '0 && elig[idx]) pick[idx] = 1'b1;
        end
    end

    assign grant = (reset_n && !hold) ? pick : '0;

    always_comb begin
        sel_tag  = '0;
        sel_data = '0;
        ptr_nxt  = rr_ptr;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                sel_tag  = tag[i*TAG_W +: TAG_W];
                sel_data = data[i*DATA_W +: DATA_W];
                ptr_nxt  = PW'((i + 1) % NUM_SRC);
            end
        end
    end

    // Tag/data hold their last value on idle cycles; consumers qualify on cdb_valid
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cdb_valid   <= 1'b0;
            qi_cdb      <= '0;
            qi_cdb_data <= '0;
            rr_ptr      <= '0;
        end else begin
            cdb_valid <= |grant;
            if (|grant) begin
                qi_cdb      <= sel_tag;
                qi_cdb_data <= sel_data;
                if (RR_MODE) rr_ptr <= ptr_nxt;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter_rr.sv
// tb_cdb_arbiter_rr: round-robin and fixed-priority instances driven in parallel,
// grants checked per cycle, broadcasts checked through per-instance scoreboards.
module tb_cdb_arbiter_rr;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int TW = 3;

    typedef struct packed {
        logic          v;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } bc_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            reset_n, hold;
    logic [N-1:0]    req;
    logic [N*TW-1:0] tag;
    logic [N*DW-1:0] data;

    logic [N-1:0]  g_rr, g_fp;
    logic          v_rr, v_fp;
    logic [TW-1:0] t_rr, t_fp;
    logic [DW-1:0] d_rr, d_fp;
    logic [1:0]    p_rr, p_fp;

    int checks = 0;
    int errors = 0;

    bc_t q_rr[$];
    bc_t q_fp[$];
    bc_t m_rr = '0, m_fp = '0, n_rr, n_fp, e_rr, e_fp;
    int mp = 0, mp_nxt = 0;
    logic [N-1:0] eg_rr, eg_fp;
    bit sb_on = 1'b0;

    cdb_arbiter_rr #(.NUM_SRC(N), .DATA_W(DW), .TAG_W(TW), .RR_MODE(1'b1)) u_rr (
        .clock(clock), .reset_n(reset_n), .req(req), .tag(tag), .data(data), .hold(hold),
        .grant(g_rr), .cdb_valid(v_rr), .qi_cdb(t_rr), .qi_cdb_data(d_rr), .rr_ptr(p_rr));

    cdb_arbiter_rr #(.NUM_SRC(N), .DATA_W(DW), .TAG_W(TW), .RR_MODE(1'b0)) u_fp (
        .clock(clock), .reset_n(reset_n), .req(req), .tag(tag), .data(data), .hold(hold),
        .grant(g_fp), .cdb_valid(v_fp), .qi_cdb(t_fp), .qi_cdb_data(d_fp), .rr_ptr(p_fp));

    function automatic logic [N-1:0] mgrant(input int p, input bit rr);
        int i;
        if (!reset_n || hold) return '0;
        for (int k = 0; k < N; k++) begin
            i = rr ? (p + k) % N : k;
            if (req[i] && tag[i*TW +: TW] != '0) return N'(1) << i;
        end
        return '0;
    endfunction

    function automatic bc_t mbc(input logic [N-1:0] g, input bc_t prev);
        bc_t r;
        r = '{v: 1'b0, tag: prev.tag, data: prev.data};
        if (!reset_n) return '0;
        for (int i = 0; i < N; i++)
            if (g[i]) r = '{v: 1'b1, tag: tag[i*TW +: TW], data: data[i*DW +: DW]};
        return r;
    endfunction

    task automatic predict();
        #3;
        eg_rr  = mgrant(mp, 1'b1);
        eg_fp  = mgrant(0, 1'b0);
        n_rr   = mbc(eg_rr, m_rr);
        n_fp   = mbc(eg_fp, m_fp);
        mp_nxt = reset_n ? mp : 0;
        for (int i = 0; i < N; i++) if (eg_rr[i]) mp_nxt = (i + 1) % N;
        if (sb_on) begin
            q_rr.push_back(n_rr);
            q_fp.push_back(n_fp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        mp   = mp_nxt;
        m_rr = n_rr;
        m_fp = n_fp;
    endtask

    always @(posedge clock) begin
        #2;
        if (q_rr.size() != 0) begin
            e_rr = q_rr.pop_front();
            checks++;
            if ({v_rr, t_rr, d_rr} !== e_rr) begin
                errors++;
                $display("FAIL sb_rr: got v=%0b tag=%0d data=%h, want v=%0b tag=%0d data=%h",
                         v_rr, t_rr, d_rr, e_rr.v, e_rr.tag, e_rr.data);
            end
        end
        if (q_fp.size() != 0) begin
            e_fp = q_fp.pop_front();
            checks++;
            if ({v_fp, t_fp, d_fp} !== e_fp) begin
                errors++;
                $display("FAIL sb_fp: got v=%0b tag=%0d data=%h, want v=%0b tag=%0d data=%h",
                         v_fp, t_fp, d_fp, e_fp.v, e_fp.tag, e_fp.data);
            end
        end
    end

    task automatic apply_reset();
        reset_n = 1'b0;
        predict();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        hold    = 1'b0;
        req     = 4'b1111;
        tag     = {3'd4, 3'd3, 3'd2, 3'd1};
        data    = {16'hD004, 16'hD003, 16'hD002, 16'hD001};
        predict();
        checks++;
        if (g_rr !== 4'b0000 || g_fp !== 4'b0000) begin
            errors++;
            $display("FAIL reset_grant: got rr=%b fp=%b, want 0000", g_rr, g_fp);
        end
        tick();
        predict();
        tick();
        checks++;
        if ({v_rr, t_rr, d_rr, p_rr} !== '0) begin
            errors++;
            $display("FAIL reset_rr: got v=%0b tag=%0d data=%h ptr=%0d, want all 0", v_rr, t_rr, d_rr, p_rr);
        end
        checks++;
        if ({v_fp, t_fp, d_fp, p_fp} !== '0) begin
            errors++;
            $display("FAIL reset_fp: got v=%0b tag=%0d data=%h ptr=%0d, want all 0", v_fp, t_fp, d_fp, p_fp);
        end
        reset_n = 1'b1;
        req     = '0;
        sb_on   = 1'b1;
    endtask

    task automatic test_single();
        req = 4'b0100;
        tag[2*TW +: TW]  = 3'd3;
        data[2*DW +: DW] = 16'hBEEF;
        predict();
        checks++;
        if (g_rr !== 4'b0100 || g_fp !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant: got rr=%b fp=%b, want 0100", g_rr, g_fp);
        end
        tick();
        checks++;
        if (v_rr !== 1'b1 || t_rr !== 3'd3 || d_rr !== 16'hBEEF || p_rr !== 2'd3) begin
            errors++;
            $display("FAIL single_bc: got v=%0b tag=%0d data=%h ptr=%0d, want 1 3 beef 3", v_rr, t_rr, d_rr, p_rr);
        end
        checks++;
        if (p_fp !== 2'd0) begin
            errors++;
            $display("FAIL single_fp_ptr: got %0d, want 0", p_fp);
        end
        req = '0;
        predict();
        tick();
        checks++;
        if (v_rr !== 1'b0 || v_fp !== 1'b0) begin
            errors++;
            $display("FAIL single_drop: got rr=%0b fp=%0b, want 0", v_rr, v_fp);
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0] exp_g;
        apply_reset();
        tag  = {3'd4, 3'd3, 3'd2, 3'd1};
        data = {16'hD004, 16'hD003, 16'hD002, 16'hD001};
        req  = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            exp_g = N'(1) << (c % N);
            predict();
            checks++;
            if (g_rr !== exp_g || g_fp !== 4'b0001) begin
                errors++;
                $display("FAIL rotation_grant[%0d]: got rr=%b fp=%b, want rr=%b fp=0001", c, g_rr, g_fp, exp_g);
            end
            tick();
            checks++;
            if (v_rr !== 1'b1 || t_rr !== 3'(c % N + 1)) begin
                errors++;
                $display("FAIL rotation_bc[%0d]: got v=%0b tag=%0d, want v=1 tag=%0d", c, v_rr, t_rr, c % N + 1);
            end
        end
        req = '0;
    endtask

    task automatic test_fixed();
        req = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            predict();
            checks++;
            if (g_fp !== 4'b0010) begin
                errors++;
                $display("FAIL fixed_grant[%0d]: got %b, want 0010", c, g_fp);
            end
            tick();
            checks++;
            if (v_fp !== 1'b1 || t_fp !== 3'd2) begin
                errors++;
                $display("FAIL fixed_bc[%0d]: got v=%0b tag=%0d, want 1 2", c, v_fp, t_fp);
            end
        end
        req = 4'b1000;
        predict();
        checks++;
        if (g_fp !== 4'b1000) begin
            errors++;
            $display("FAIL fixed_after_drop: got %b, want 1000", g_fp);
        end
        tick();
        req = '0;
        predict();
        tick();
    endtask

    task automatic test_hold_tag0();
        int p0;
        p0   = mp;
        req  = 4'b0011;
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            predict();
            checks++;
            if (g_rr !== 4'b0000 || g_fp !== 4'b0000) begin
                errors++;
                $display("FAIL hold_grant[%0d]: got rr=%b fp=%b, want 0000", c, g_rr, g_fp);
            end
            tick();
            checks++;
            if (v_rr !== 1'b0 || v_fp !== 1'b0 || p_rr !== 2'(p0)) begin
                errors++;
                $display("FAIL hold_state[%0d]: got v=%0b/%0b ptr=%0d, want v=0/0 ptr=%0d", c, v_rr, v_fp, p_rr, p0);
            end
        end
        hold = 1'b0;
        predict();
        checks++;
        if (g_rr !== eg_rr || g_rr === 4'b0000 || g_fp !== 4'b0001) begin
            errors++;
            $display("FAIL hold_resume: got rr=%b fp=%b, want rr=%b fp=0001", g_rr, g_fp, eg_rr);
        end
        tick();
        req = 4'b0001;
        tag[0 +: TW] = 3'd0;
        for (int c = 0; c < 3; c++) begin
            predict();
            checks++;
            if (g_rr !== 4'b0000 || g_fp !== 4'b0000) begin
                errors++;
                $display("FAIL tag0_grant[%0d]: got rr=%b fp=%b, want 0000", c, g_rr, g_fp);
            end
            tick();
        end
        tag[0 +: TW] = 3'd1;
        req = '0;
    endtask

    task automatic test_wrap_reset();
        req = 4'b0100;
        predict();
        tick();
        checks++;
        if (p_rr !== 2'd3) begin
            errors++;
            $display("FAIL wrap_setup: got ptr=%0d, want 3", p_rr);
        end
        req = 4'b1001;
        predict();
        checks++;
        if (g_rr !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_grant3: got %b, want 1000", g_rr);
        end
        tick();
        checks++;
        if (p_rr !== 2'd0 || t_rr !== 3'd4) begin
            errors++;
            $display("FAIL wrap_ptr: got ptr=%0d tag=%0d, want 0 4", p_rr, t_rr);
        end
        predict();
        checks++;
        if (g_rr !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_grant0: got %b, want 0001", g_rr);
        end
        tick();
        req = 4'b1111;
        predict();
        tick();
        reset_n = 1'b0;
        predict();
        checks++;
        if (g_rr !== 4'b0000 || g_fp !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_grant: got rr=%b fp=%b, want 0000", g_rr, g_fp);
        end
        tick();
        checks++;
        if (v_rr !== 1'b0 || p_rr !== 2'd0 || t_rr !== 3'd0 || v_fp !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: got v=%0b ptr=%0d tag=%0d fp_v=%0b, want 0 0 0 0", v_rr, p_rr, t_rr, v_fp);
        end
        reset_n = 1'b1;
        req = '0;
        predict();
        tick();
    endtask

    task automatic test_back_to_back();
        req = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            data[1*DW +: DW] = 16'hA000 + DW'(c);
            predict();
            checks++;
            if (g_rr !== 4'b0010) begin
                errors++;
                $display("FAIL b2b_grant[%0d]: got %b, want 0010", c, g_rr);
            end
            tick();
            checks++;
            if (v_rr !== 1'b1 || d_rr !== 16'hA000 + DW'(c)) begin
                errors++;
                $display("FAIL b2b_bc[%0d]: got v=%0b data=%h, want 1 %h", c, v_rr, d_rr, 16'hA000 + DW'(c));
            end
        end
        req = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 40; c++) begin
            req  = N'($urandom);
            tag  = (N*TW)'($urandom);
            data = {$urandom, $urandom};
            hold = ($urandom_range(0, 4) == 0);
            predict();
            checks++;
            if (g_rr !== eg_rr || g_fp !== eg_fp) begin
                errors++;
                $display("FAIL random_grant[%0d]: got rr=%b fp=%b, want rr=%b fp=%b", c, g_rr, g_fp, eg_rr, eg_fp);
            end
            tick();
            checks++;
            if (p_rr !== 2'(mp) || p_fp !== 2'd0) begin
                errors++;
                $display("FAIL random_ptr[%0d]: got rr=%0d fp=%0d, want rr=%0d fp=0", c, p_rr, p_fp, mp);
            end
        end
        hold = 1'b0;
        req  = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_fixed();
        test_hold_tag0();
        test_wrap_reset();
        test_back_to_back();
        test_random();
        predict();
        tick();
        #3;
        checks++;
        if (q_rr.size() != 0 || q_fp.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d/%0d entries left, want 0", q_rr.size(), q_fp.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter_rr.md
Name: cdb_arbiter_rr

Overview:
- Parametrised Common Data Bus arbiter for the Tomasulo core.
- Accepts completion requests from NUM_SRC functional-unit / reservation-station sources (ADD, LOAD, future MUL) and grants at most one per cycle.
- Drives the registered CDB broadcast (tag, data, valid) consumed by reservation stations and the register status table.
- Supports fixed-priority and round-robin arbitration, a valid/grant handshake so losing sources hold their result, and a global hold input.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- DATA_W, 16, CDB data width.
- TAG_W, 3, reservation-station tag width; tag 0 means "free register / no producer".
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).

Ports:
- Clock  in  1  system clock, all state updates on rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- Req  in  NUM_SRC  per-source request; held high with Tag_in/Data_in stable until granted.
- Tag_in  in  NUM_SRC*TAG_W  packed source tags, source i at bits [i*TAG_W +: TAG_W].
- Data_in  in  NUM_SRC*DATA_W  packed source results, source i at bits [i*DATA_W +: DATA_W].
- Hold  in  1  when 1, no grant is issued this cycle (CDB stalled).
- Grant  out  NUM_SRC  one-hot combinational grant; source i may drop Req after the edge where Grant[i]=1.
- CDB_valid  out  1  registered, 1 for exactly one cycle per accepted broadcast.
- Qi_CDB  out  TAG_W  registered broadcast tag.
- Qi_CDB_data  out  DATA_W  registered broadcast data.
- Rr_ptr  out  clog2(NUM_SRC)  current round-robin highest-priority index (debug/verification).

Behaviour:
- Reset (Reset_n=0 at a rising edge): CDB_valid=0, Qi_CDB=0, Qi_CDB_data=0, Rr_ptr=0. Grant=0 while Reset_n=0 regardless of Req. A request pending at reset is discarded; the source must re-present it.
- Eligibility: source i is eligible iff Req[i]=1 and its tag is nonzero. Tag 0 requests are never granted; Req is ignored for them.
- Grant (combinational):
  - If Hold=1 or no source is eligible, Grant=0.
  - RR_MODE=0: lowest-index eligible source wins.
  - RR_MODE=1: first eligible index searching Rr_ptr, Rr_ptr+1, ..., wrapping modulo NUM_SRC.
- Broadcast (registered, 1-cycle latency from grant):
  - On the edge where Grant[i]=1: CDB_valid<=1, Qi_CDB<=tag i, Qi_CDB_data<=data i.
  - On an edge with no grant: CDB_valid<=0; Qi_CDB and Qi_CDB_data keep their previous values.
  - Consumers must qualify on CDB_valid.
- Pointer: in RR_MODE=1, on a granted edge Rr_ptr<=(i+1) mod NUM_SRC, wrapping from NUM_SRC-1 to 0. Rr_ptr is unchanged when no grant occurs or when RR_MODE=0.
- Back-to-back: one broadcast per cycle maximum. A source may be granted in consecutive cycles if it re-requests with new data and, in RR mode, no other source is eligible.
- Losers keep Req asserted. The arbiter keeps no per-source queue; buffering is the source's responsibility.
- Hold: with Hold=1 for k cycles, CDB_valid=0 for those cycles and Rr_ptr is frozen. Arbitration resumes on the first cycle with Hold=0.
- Fairness: in RR_MODE=1 every continuously eligible source is granted within NUM_SRC granted cycles.

Test Plan:
- Reset: Reset_n=0 with Req=4'b1111 -> Grant=0; after the edge CDB_valid=0, Qi_CDB=0, Qi_CDB_data=0, Rr_ptr=0.
- Single request: Req=4'b0100, tag2=3, data2=16'hBEEF -> Grant=4'b0100; next cycle CDB_valid=1, Qi_CDB=3, Qi_CDB_data=16'hBEEF, Rr_ptr=3; following cycle CDB_valid=0.
- Round-robin rotation (RR_MODE=1): Req=4'b1111 held for 5 cycles with tags 1..4 -> grant order 0,1,2,3,0; broadcast tags 1,2,3,4,1 on consecutive cycles with CDB_valid=1 continuously.
- Fixed priority (RR_MODE=0): Req=4'b1010 held -> Grant=4'b0010 every cycle while Req[1]=1; source 3 is granted only after Req[1] drops.
- Hold and tag-0 filtering: Req=4'b0011 with Hold=1 for 3 cycles -> Grant=0, CDB_valid=0, Rr_ptr frozen; Hold=0 -> grant resumes. Source 0 tag=0 with Req[0]=1 alone -> never granted.
- Wrap and reset mid-stream: Rr_ptr=3, Req=4'b1001 -> grant 3, then Rr_ptr=0 and grant 0. Reset_n=0 asserted on the grant edge -> CDB_valid=0 and Rr_ptr=0 next cycle, with no broadcast of that grant.
